// File: rtl/baud_pkg.sv
// Shared constants and helpers for the UART baud tick generator.
// Default divisor derivation and oversampling-factor legality check.
package baud_pkg;

  localparam int unsigned DIV_W_DEF  = 24;
  localparam int unsigned FRAC_W_DEF = 4;
  localparam int unsigned OVS_MIN    = 4;
  localparam int unsigned OVS_MAX    = 64;
  localparam int unsigned DIV_MIN    = 2;

  // Fixed-point clocks per oversample tick, frac_w fraction bits.
  function automatic longint unsigned def_div(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input longint unsigned ovs,
    input int unsigned     frac_w
  );
    return (clk_hz << frac_w) / (baud * ovs);
  endfunction

  function automatic bit ovs_legal(input int unsigned ovs);
    return (ovs >= OVS_MIN) && (ovs <= OVS_MAX) &&
           ((ovs & (ovs - 1)) == 0);
  endfunction

endpackage

// File: rtl/baud_frac_div.sv
// Prescaler with optional fractional accumulator (BAUD_FRAC_EN).
// tick_o is a combinational strobe; the parent registers it.
module baud_frac_div
  import baud_pkg::*;
#(
  parameter int unsigned      DIV_W   = DIV_W_DEF,
  parameter int unsigned      FRAC_W  = FRAC_W_DEF,
  parameter logic [DIV_W-1:0] RST_CNT = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              restart_i,
  input  logic [DIV_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  output logic              tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             carry;
  logic             fire;

  assign fire   = en_i & (cnt_q == '0);
  assign tick_o = fire & ~restart_i;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   sum;

  assign sum   = {1'b0, acc_q} + {1'b0, div_frac_i};
  assign carry = sum[FRAC_W];

  always_comb begin
    acc_d = acc_q;
    if (restart_i) acc_d = '0;
    else if (fire) acc_d = sum[FRAC_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end
`else
  logic unused_frac;
  assign unused_frac = ^div_frac_i;
  assign carry       = 1'b0;
`endif

  // Carry from this tick stretches the period being loaded now.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i)
      cnt_d = div_int_i - 1'b1;
    else if (fire)
      cnt_d = div_int_i - 1'b1 + {{(DIV_W-1){1'b0}}, carry};
    else if (en_i)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= RST_CNT;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/baud_tick_gen.sv
// UART oversample / bit / mid-bit tick generator, runtime divisor.
// Fractional divisor support is built only with BAUD_FRAC_EN.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int unsigned pClkFreq = 50000000,
  parameter int unsigned pBaud    = 19200,
  parameter int unsigned pOvs     = 16,
  parameter int unsigned pDivW    = DIV_W_DEF,
  parameter int unsigned pFracW   = FRAC_W_DEF
) (
  input  logic              CLOCK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              DIV_LD,
  input  logic [pDivW-1:0]  DIV_INT,
  input  logic [pFracW-1:0] DIV_FRAC,
  input  logic              RESYNC,
  output logic              OVS_TICK,
  output logic              BAUD,
  output logic              BAUD_HALF,
  output logic              DIV_ERR
);

  localparam int unsigned PH_W = $clog2(pOvs);
  localparam longint unsigned DEF =
    def_div(pClkFreq, pBaud, pOvs, pFracW);
  localparam logic [pDivW-1:0] DEF_INT =
    pDivW'(DEF >> pFracW);
`ifdef BAUD_FRAC_EN
  localparam logic [pFracW-1:0] DEF_FRAC = pFracW'(DEF);
`else
  localparam logic [pFracW-1:0] DEF_FRAC = '0;
`endif
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(pOvs - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(pOvs / 2 - 1);

  if (!ovs_legal(pOvs)) begin : g_bad_ovs
    $error("baud_tick_gen: pOvs must be a power of two in 4..64");
  end

  logic [pDivW-1:0]  int_q, int_d, sh_int_q, sh_int_d;
  logic [pFracW-1:0] frac_q, frac_d, sh_frac_q, sh_frac_d;
  logic              pend_q, pend_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic              tick_q, baud_q, half_q, err_q;
  logic [pDivW-1:0]  eff_int;
  logic [pFracW-1:0] eff_frac;
  logic [pFracW-1:0] ld_frac;
  logic              ld_ok, ld_bad, tick;

`ifdef BAUD_FRAC_EN
  assign ld_frac = DIV_FRAC;
`else
  logic unused_div_frac;
  assign unused_div_frac = ^DIV_FRAC;
  assign ld_frac         = '0;
`endif

  assign ld_ok  = DIV_LD & (DIV_INT >= pDivW'(DIV_MIN));
  assign ld_bad = DIV_LD & ~ld_ok;

  // Divisor the prescaler uses if it reloads this cycle.
  always_comb begin
    eff_int  = int_q;
    eff_frac = frac_q;
    if (ld_ok && RESYNC) begin
      eff_int  = DIV_INT;
      eff_frac = ld_frac;
    end else if (pend_q) begin
      eff_int  = sh_int_q;
      eff_frac = sh_frac_q;
    end
  end

  baud_frac_div #(
    .DIV_W   (pDivW),
    .FRAC_W  (pFracW),
    .RST_CNT (DEF_INT - 1'b1)
  ) u_div (
    .clk_i      (CLOCK),
    .rst_ni     (RST_N),
    .en_i       (EN),
    .restart_i  (RESYNC),
    .div_int_i  (eff_int),
    .div_frac_i (eff_frac),
    .tick_o     (tick)
  );

  always_comb begin
    int_d     = int_q;
    frac_d    = frac_q;
    sh_int_d  = sh_int_q;
    sh_frac_d = sh_frac_q;
    pend_d    = pend_q;
    if (pend_q && (tick || RESYNC)) begin
      int_d  = sh_int_q;
      frac_d = sh_frac_q;
      pend_d = 1'b0;
    end
    if (ld_ok) begin
      if (!EN || RESYNC) begin
        int_d  = DIV_INT;
        frac_d = ld_frac;
        pend_d = 1'b0;
      end else begin
        sh_int_d  = DIV_INT;
        sh_frac_d = ld_frac;
        pend_d    = 1'b1;
      end
    end
  end

  always_comb begin
    ph_d = ph_q;
    if (RESYNC)    ph_d = '0;
    else if (tick) ph_d = ph_q + 1'b1;
  end

  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      int_q     <= DEF_INT;
      frac_q    <= DEF_FRAC;
      sh_int_q  <= DEF_INT;
      sh_frac_q <= DEF_FRAC;
      pend_q    <= 1'b0;
      ph_q      <= '0;
      tick_q    <= 1'b0;
      baud_q    <= 1'b0;
      half_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      int_q     <= int_d;
      frac_q    <= frac_d;
      sh_int_q  <= sh_int_d;
      sh_frac_q <= sh_frac_d;
      pend_q    <= pend_d;
      ph_q      <= ph_d;
      tick_q    <= tick;
      baud_q    <= tick & (ph_q == PH_LAST);
      half_q    <= tick & (ph_q == PH_MID);
      err_q     <= ld_bad;
    end
  end

  assign OVS_TICK  = tick_q;
  assign BAUD      = baud_q;
  assign BAUD_HALF = half_q;
  assign DIV_ERR   = err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen, default parameters (pOvs=16).
// Expected edge counts are hand-derived from the divisor settings.
module tb_baud_tick_gen;

  localparam int LIMIT = 5000;

  logic        CLOCK = 1'b0;
  logic        RST_N = 1'b0;
  logic        EN = 1'b1;
  logic        DIV_LD = 1'b0;
  logic [23:0] DIV_INT = '0;
  logic [3:0]  DIV_FRAC = '0;
  logic        RESYNC = 1'b0;
  logic        OVS_TICK, BAUD, BAUD_HALF, DIV_ERR;

  int nvec = 0;
  int nerr = 0;

  baud_tick_gen dut (
    .CLOCK     (CLOCK),
    .RST_N     (RST_N),
    .EN        (EN),
    .DIV_LD    (DIV_LD),
    .DIV_INT   (DIV_INT),
    .DIV_FRAC  (DIV_FRAC),
    .RESYNC    (RESYNC),
    .OVS_TICK  (OVS_TICK),
    .BAUD      (BAUD),
    .BAUD_HALF (BAUD_HALF),
    .DIV_ERR   (DIV_ERR)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input int got,
                       input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Edges until the selected output is seen high (0 ovs, 1 baud, 2 half).
  task automatic wait_for(input int sel, output int n);
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < LIMIT) begin
      @(posedge CLOCK);
      #1;
      n++;
      case (sel)
        0:       hit = OVS_TICK;
        1:       hit = BAUD;
        default: hit = BAUD_HALF;
      endcase
    end
  endtask

  task automatic strobe(input logic ld, input logic rs,
                        input int di, input int df);
    DIV_LD   = ld;
    RESYNC   = rs;
    DIV_INT  = 24'(di);
    DIV_FRAC = 4'(df);
    @(posedge CLOCK);
    #1;
    DIV_LD = 1'b0;
    RESYNC = 1'b0;
  endtask

  function automatic int outs();
    return {28'd0, OVS_TICK, BAUD, BAUD_HALF, DIV_ERR};
  endfunction

  initial begin
    int n, sum, idx, half_idx, baud_idx, cnt;
    half_idx = 0;
    baud_idx = 0;

    repeat (2) @(posedge CLOCK);
    #1;
    check("rst_outs", outs(), 0);
    @(negedge CLOCK);
    RST_N = 1'b1;

    wait_for(0, n);
    check("rst_first_tick", n, 162);
    check("rst_tick1_baud", {31'd0, BAUD}, 0);
    for (int i = 2; i <= 16; i++) begin
      wait_for(0, n);
      if (i == 2) check("rst_period", n, 162);
      if (BAUD_HALF && half_idx == 0) half_idx = i;
      if (BAUD && baud_idx == 0) baud_idx = i;
    end
    check("rst_half_idx", half_idx, 8);
    check("rst_baud_idx", baud_idx, 16);

    strobe(1'b1, 1'b1, 4, 0);
    check("ld_rs_no_err", {31'd0, DIV_ERR}, 0);
    wait_for(0, n);
    check("ld_rs_first", n, 4);
    wait_for(0, n);
    check("div4_period", n, 4);
    wait_for(1, n);
    check("div4_baud1", n, 56);
    wait_for(2, n);
    check("div4_half", n, 32);
    wait_for(1, n);
    check("div4_baud2", n, 32);

    strobe(1'b1, 1'b1, 4, 8);
    wait_for(0, n);
    check("frac_first", n, 4);
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      wait_for(0, n);
      sum += n;
    end
`ifdef BAUD_FRAC_EN
    check("frac_16ticks", sum, 72);
`else
    check("frac_16ticks", sum, 64);
`endif

    strobe(1'b1, 1'b1, 2, 0);
    wait_for(0, n);
    check("div2_first", n, 2);
    wait_for(0, n);
    check("div2_period", n, 2);

    strobe(1'b1, 1'b1, 4, 0);
    wait_for(0, n);
    check("div4_again", n, 4);

    strobe(1'b1, 1'b0, 1, 0);
    check("err_pulse", {31'd0, DIV_ERR}, 1);
    @(posedge CLOCK);
    #1;
    check("err_clear", {31'd0, DIV_ERR}, 0);
    wait_for(0, n);
    check("err_rest", n, 2);
    wait_for(0, n);
    check("err_period", n, 4);

    strobe(1'b1, 1'b0, 6, 0);
    wait_for(0, n);
    check("ld6_current", n, 3);
    wait_for(0, n);
    check("ld6_next", n, 6);

    wait_for(1, n);
    for (int i = 0; i < 9; i++) wait_for(0, n);
    strobe(1'b0, 1'b1, 0, 0);
    wait_for(2, n);
    check("rs_half", n, 48);
    wait_for(1, n);
    check("rs_baud", n, 48);

    strobe(1'b0, 1'b1, 0, 0);
    repeat (5) @(posedge CLOCK);
    #1;
    RESYNC = 1'b1;
    @(posedge CLOCK);
    #1;
    RESYNC = 1'b0;
    check("rs_suppress", {31'd0, OVS_TICK}, 0);
    wait_for(0, n);
    check("rs_supp_next", n, 6);

    EN  = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(posedge CLOCK);
      #1;
      if (OVS_TICK) cnt++;
    end
    EN = 1'b1;
    check("en_off_ticks", cnt, 0);
    wait_for(0, n);
    check("en_delay", n, 6);

    wait_for(1, n);
    idx = outs();
    check("pre_rst_baud", idx, 12);
    RST_N = 1'b0;
    #1;
    check("rst_async", outs(), 0);
    @(negedge CLOCK);
    RST_N = 1'b1;
    wait_for(0, n);
    check("rst_dflt_div", n, 162);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised baud-rate tick generator for the UART receive and transmit paths, replacing the fixed single-rate divider. Produces an oversampling tick, a bit-rate tick and a mid-bit sample tick from a runtime-loadable divisor with optional fractional part. A phase-restart input re-aligns all ticks to a receiver start-bit edge.

## Interface
- pClkFreq, 50000000: input clock frequency in Hz.
- pBaud, 19200: reset baud rate.
- pOvs, 16: oversampling factor, power of two, 4..64.
- pDivW, 24: integer divisor width.
- pFracW, 4: fractional divisor width.
- CLOCK  in  1  sole clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- EN  in  1  count enable; low freezes all counters.
- DIV_LD  in  1  one-cycle strobe; captures DIV_INT/DIV_FRAC.
- DIV_INT  in  pDivW  integer clocks per oversample tick.
- DIV_FRAC  in  pFracW  fractional clocks per oversample tick, units of 2^-pFracW.
- RESYNC  in  1  one-cycle strobe; restarts bit phase.
- OVS_TICK  out  1  one-cycle pulse per oversample period.
- BAUD  out  1  one-cycle pulse per bit period.
- BAUD_HALF  out  1  one-cycle pulse at mid-bit.
- DIV_ERR  out  1  one-cycle pulse; rejected divisor load.

## Operation
- Divisor register {div_int, div_frac}; reset value is floor(pClkFreq·2^pFracW/(pBaud·pOvs)) split into integer and fractional fields (defaults: 162, 12).
- Prescaler: down-counter cnt loads div_int−1, plus 1 when the fractional carry is pending; OVS_TICK fires when cnt==0 and EN=1.
- Fractional accumulator acc (pFracW bits): on each OVS_TICK, acc ← acc + div_frac; carry-out lengthens the next period by one clock. Over 2^pFracW ticks exactly div_frac periods are div_int+1 long.
- Phase counter ph (log2(pOvs) bits) increments on OVS_TICK and wraps pOvs−1→0.
- BAUD = OVS_TICK & (ph==pOvs−1); BAUD_HALF = OVS_TICK & (ph==pOvs/2−1).
- DIV_LD with DIV_INT≥2: values captured into a shadow register and applied at the next OVS_TICK boundary (the reload of cnt). If EN=0 they apply immediately.
- DIV_LD with DIV_INT<2: DIV_ERR pulses the following cycle; active divisor and any pending shadow value are unchanged.
- RESYNC: cnt, acc, ph cleared to reload state; the first OVS_TICK follows a full div_int period, and BAUD_HALF follows pOvs/2 ticks later. A RESYNC coinciding with a tick suppresses that tick.
- RESYNC with DIV_LD in the same cycle: the new divisor (if valid) applies immediately and the restart uses it.
- EN=0: all counters hold and tick outputs are 0. Returning to EN=1 resumes mid-period. RESYNC and DIV_LD remain honoured while EN=0.

## Timing
- All outputs registered; reset value 0 for OVS_TICK, BAUD, BAUD_HALF and DIV_ERR.
- After RST_N release or RESYNC, with div_int=N and frac=0: OVS_TICK on the Nth rising edge, then every N clocks.
- BAUD and BAUD_HALF coincide with the OVS_TICK pulse of the same cycle. Zero extra latency.
- DIV_ERR is asserted exactly one cycle after the offending DIV_LD.
- Asserting RST_N mid-period clears all state asynchronously; no partial tick is emitted.

## Configuration
- BAUD_FRAC_EN defined: fractional accumulator and DIV_FRAC capture are present, as above.
- BAUD_FRAC_EN undefined: accumulator removed, DIV_FRAC ignored, period is exactly div_int clocks, and the reset divisor uses only the integer field. Ports are unchanged.

## Structure
- Package baud_pkg: width constants, the default-divisor constant function, and the pOvs legality check.
- Sub-module baud_frac_div: prescaler plus fractional accumulator, producing the OVS_TICK strobe. The top level holds the divisor and shadow registers, the phase counter and the tick decode.

## Test plan
- Reset defaults: after RST_N release, first OVS_TICK at clock 162 and BAUD after 16 ticks; outputs are 0 during reset.
- pOvs=4, load DIV_INT=4, DIV_FRAC=0 -> OVS_TICK every 4 clocks, BAUD every 16 clocks, BAUD_HALF at ph==1.
- Load DIV_INT=4, DIV_FRAC=8 (pFracW=4) -> periods alternate 4,5; 16 ticks take exactly 72 clocks. Without BAUD_FRAC_EN they take 64.
- Load DIV_INT=1 -> DIV_ERR pulses one cycle later and the period is unchanged. Load DIV_INT=6 mid-period -> the current period completes at the old length and the next period is 6.
- RESYNC at ph=9 -> ph restarts at 0; BAUD_HALF lands pOvs/2 ticks later. RESYNC together with DIV_LD -> the new divisor applies to the very first period.
- Drop EN for 10 clocks mid-period -> no ticks, and the tick is delayed by exactly 10 clocks. Pulse RST_N mid-bit -> all outputs drop to 0 asynchronously and the default divisor is restored.
